// File: rtl/debug_disp_pkg.sv
// debug_disp_pkg: shared types and constants for the debug display front end.
// Holds the channel-select mode enum, the key debounce state enum and the
// active-low seven-segment glyph table ({a..g}, bit 6 = segment a).
package debug_disp_pkg;

  typedef enum logic [1:0] {
    MODE_SW   = 2'd0,
    MODE_STEP = 2'd1,
    MODE_AUTO = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_e;

  // All segments off (outputs are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyphs 0..F, active-low {a,b,c,d,e,f,g}; index 0 is the leftmost entry.
  localparam logic [0:15][6:0] HEX_SEG = {
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  // Raw mode pins to mode; the unused encoding 3 behaves as switch select.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_STEP;
      2'd2:    return MODE_AUTO;
      default: return MODE_SW;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser for the raw active-low step key followed
// by a press/release debounce FSM. A press qualifies after DEBOUNCE_CYC
// consecutive low samples and yields exactly one StepPulse; the key must then
// be seen high for DEBOUNCE_CYC consecutive samples before it can fire again.
module key_debounce
  import debug_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic KeyStepN,
  output logic StepPulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  // With a one-cycle qualification the first opposite sample already settles.
  localparam bit ONE_CYC = (DEBOUNCE_CYC <= 1);

  logic [1:0]       sync_q;
  logic             key_sync;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  assign key_sync  = sync_q[1];
  assign StepPulse = pulse_q;

  // Synchroniser resets to the released (high) level so no false press appears.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], KeyStepN};
    end
  end

  // Debounce state, run-length counter and the registered pulse.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: the counter holds how many consecutive samples of the awaited
  // level have been seen, the entering sample counting as the first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (!key_sync) begin
          cnt_d = CNT_W'(1);
          if (ONE_CYC) begin
            state_d = DB_HELD;
            pulse_d = 1'b1;
          end else begin
            state_d = DB_PRESS_WAIT;
          end
        end
      end
      DB_PRESS_WAIT: begin
        if (key_sync) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_HELD: begin
        if (key_sync) begin
          cnt_d   = CNT_W'(1);
          state_d = ONE_CYC ? DB_IDLE : DB_RELEASE_WAIT;
        end
      end
      DB_RELEASE_WAIT: begin
        if (!key_sync) begin
          state_d = DB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/debug_display_mux.sv
// debug_display_mux: picks one of NUM_CH debug channels (switches, debounced
// step key or timed auto scan), optionally freezes it, and drives DIGITS
// registered active-low hex displays.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the most
// significant nonzero digit (digit 0 always lit).
module debug_display_mux
  import debug_disp_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int DATA_W       = 16,
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SCAN_CYC     = 50000000
) (
  input  logic                     CLOCK_50,
  input  logic                     Reset,
  input  logic [NUM_CH*DATA_W-1:0] ChData,
  input  logic [1:0]               Mode,
  input  logic [3:0]               Sel,
  input  logic                     KeyStepN,
  input  logic                     Freeze,
  output logic [7*DIGITS-1:0]      Hex,
  output logic [3:0]               ChIdx,
  output logic                     StepPulse
);

  localparam int DISP_W = 4 * DIGITS;
  localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
  localparam logic [3:0] LAST_CH  = 4'(NUM_CH - 1);
  localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

  logic                step_pulse;
  logic [DATA_W-1:0]   ch_arr [NUM_CH];
  logic [DISP_W-1:0]   live_val;
  logic [DISP_W-1:0]   disp_val;
  logic [3:0]          chidx_q, chidx_d, chidx_inc;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [DISP_W-1:0]   snap_q, snap_d;
  logic                freeze_q, freeze_rise;
  mode_e               mode_q, mode_eff;
  logic [7*DIGITS-1:0] hex_q, hex_d;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .KeyStepN (KeyStepN),
    .StepPulse(step_pulse)
  );

  assign StepPulse   = step_pulse;
  assign Hex         = hex_q;
  assign ChIdx       = chidx_q;
  assign mode_eff    = decode_mode(Mode);
  assign freeze_rise = Freeze & ~freeze_q;
  assign chidx_inc   = (chidx_q == LAST_CH) ? 4'd0 : chidx_q + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_arr[gi] = ChData[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Live value: selected channel, zero-extended to the display width.
  always_comb begin
    live_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chidx_q == 4'(k)) begin
        live_val[DATA_W-1:0] = ch_arr[k];
      end
    end
  end

  // Channel select, scan timer and snapshot. Freeze blocks every index change
  // (a coincident step pulse is dropped); on the rising edge the live value is
  // both shown and captured, afterwards the snapshot is shown.
  always_comb begin
    chidx_d  = chidx_q;
    scan_d   = scan_q;
    snap_d   = snap_q;
    disp_val = (Freeze && !freeze_rise) ? snap_q : live_val;
    if (freeze_rise) begin
      snap_d = live_val;
    end
    if (!Freeze) begin
      case (mode_eff)
        MODE_SW: begin
          scan_d = '0;
          if ({1'b0, Sel} < NUM_CH_W) begin
            chidx_d = Sel;
          end
        end
        MODE_STEP: begin
          scan_d = '0;
          if (step_pulse) begin
            chidx_d = chidx_inc;
          end
        end
        MODE_AUTO: begin
          if (step_pulse) begin
            chidx_d = chidx_inc;
            scan_d  = '0;
          end else if (mode_eff != mode_q) begin
            scan_d = '0;
          end else if (scan_q == SCAN_LAST) begin
            chidx_d = chidx_inc;
            scan_d  = '0;
          end else begin
            scan_d = scan_q + 1'b1;
          end
        end
        default: scan_d = '0;
      endcase
    end
  end

  // Per-digit glyph lookup on the value chosen for display.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib = disp_val[gi*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign hex_d[6:0] = HEX_SEG[nib];
      end else begin : g_upper
        assign hex_d[gi*7 +: 7] = (disp_val[DISP_W-1:gi*4] == '0) ? SEG_BLANK : HEX_SEG[nib];
      end
`else
      assign hex_d[gi*7 +: 7] = HEX_SEG[nib];
`endif
    end
  endgenerate

  // State registers; the display itself is registered after decode.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      chidx_q  <= 4'd0;
      scan_q   <= '0;
      snap_q   <= '0;
      freeze_q <= 1'b0;
      mode_q   <= MODE_SW;
      hex_q    <= '1;
    end else begin
      chidx_q  <= chidx_d;
      scan_q   <= scan_d;
      snap_q   <= snap_d;
      freeze_q <= Freeze;
      mode_q   <= mode_eff;
      hex_q    <= hex_d;
    end
  end

endmodule

// File: doc/debug_display_mux.md
# debug_display_mux

Parametrised debug-display front end for the DE2 board. It takes NUM_CH packed debug channels from the processor (PC, State, ALU operands and result, NextState, …) and drives DIGITS seven-segment displays with one channel at a time. The channel is chosen in one of three ways: by switches, by a debounced step key, or by automatic timed scanning. It sits between the processor debug taps and the HEX outputs of the top level, and replaces the fixed 8-to-1 mux plus the external key filter.

## Interface
Parameters:
- NUM_CH, 8: number of debug channels, 2..16.
- DATA_W, 16: width of each channel. Must satisfy DATA_W ≤ 4*DIGITS.
- DIGITS, 4: number of hex digits driven, 1..8.
- DEBOUNCE_CYC, 500000: number of consecutive stable cycles that qualify a key level.
- SCAN_CYC, 50000000: dwell time per channel in auto mode, in cycles.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- ChData  in  NUM_CH*DATA_W  packed channels; channel k is bits [k*DATA_W +: DATA_W].
- Mode  in  2  0 = switch select, 1 = key step, 2 = auto scan, 3 = treated as 0.
- Sel  in  4  channel index used in mode 0.
- KeyStepN  in  1  raw, asynchronous, active-low push button.
- Freeze  in  1  level; while high, the displayed value and ChIdx are held.
- Hex  out  7*DIGITS  active-low segments {a..g}; digit d is bits [d*7 +: 7]; digit 0 is least significant.
- ChIdx  out  4  index of the displayed channel.
- StepPulse  out  1  one-cycle pulse per qualified key press.

## Operation
- KeyStepN passes through a 2-flop synchroniser, then a debounce FSM:
  - IDLE → PRESS_WAIT on sync low.
  - PRESS_WAIT → HELD after DEBOUNCE_CYC consecutive low cycles, which emits StepPulse; any high sample returns it to IDLE.
  - HELD → RELEASE_WAIT on sync high.
  - RELEASE_WAIT → IDLE after DEBOUNCE_CYC consecutive high cycles; any low sample returns it to HELD.
- Exactly one StepPulse per press, whatever the hold time.
- Mode 0: ChIdx loads Sel when Sel < NUM_CH. Otherwise ChIdx holds its previous value.
- Mode 1: each StepPulse increments ChIdx, wrapping from NUM_CH-1 to 0.
- Mode 2: a scan counter counts 0..SCAN_CYC-1. On its terminal count ChIdx increments with wrap. StepPulse also advances ChIdx immediately and restarts the counter.
- Any change of Mode clears the scan counter. ChIdx keeps its value.
- Displayed value = ChData[ChIdx], zero-extended to 4*DIGITS bits. Each nibble is decoded to a hex glyph (0-F).
- Freeze rising edge captures the current displayed value into a snapshot register. While Freeze is high:
  - the snapshot is shown;
  - ChIdx holds;
  - StepPulse is still emitted but does not change ChIdx;
  - the scan counter holds.
- On Freeze fall, live tracking resumes on the next cycle.

## Timing
- Reset values:
  - Hex = all segments off (all ones);
  - ChIdx = 0;
  - StepPulse = 0;
  - debounce FSM = IDLE;
  - scan counter = 0;
  - snapshot = 0.
- Latency:
  - ChData or ChIdx change → Hex update: 1 cycle (registered decode).
  - Key edge → StepPulse: 2 synchroniser cycles + DEBOUNCE_CYC cycles.
  - StepPulse → ChIdx change: same edge as StepPulse is registered, so it is visible in the cycle after the pulse.
- Simultaneous events:
  - Freeze rise and StepPulse in the same cycle: Freeze wins and ChIdx does not change.
  - Scan terminal count and StepPulse in the same cycle: ChIdx advances by 1 only.
  - Reset asserted mid-debounce or mid-freeze: all state returns to reset values on the next edge, and any pending press is discarded.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: zero digits above the most significant nonzero digit are blanked (all ones). Digit 0 is always lit, so a value of 0 shows "0".
  - Undefined: all DIGITS digits are always lit, including leading zeros.

## Structure
- Package debug_disp_pkg holds:
  - the mode enum (MODE_SW, MODE_STEP, MODE_AUTO);
  - the debounce state enum;
  - the 16-entry hex-to-segment constant array;
  - the SEG_BLANK constant.
- One sub-module, key_debounce: synchroniser plus debounce FSM, parametrised by DEBOUNCE_CYC, with output StepPulse.
- Channel select, scan counter, freeze snapshot and decode stay in debug_display_mux.

## Test plan
All scenarios use NUM_CH=5, DATA_W=16, DIGITS=4, DEBOUNCE_CYC=4, SCAN_CYC=10, and channel k = 16'h1111*k.
- Reset: hold Reset 3 cycles → Hex all 1s, ChIdx=0. One cycle after release, Hex shows "0000" (or only digit 0 lit with LEADING_ZERO_BLANK_EN).
- Mode 0 select: Sel=3 → ChIdx=3 and Hex shows "3333" next cycle. Then Sel=7 → ChIdx stays 3.
- Key bounce: KeyStepN toggles low/high every 2 cycles for 20 cycles, then held low for 10 cycles → exactly one StepPulse. In mode 1, ChIdx goes 4→0 (wrap).
- Auto scan: Mode=2 from ChIdx=0 → ChIdx advances every 10 cycles: 1, 2, 3, 4, 0.
- Freeze: in mode 2 at ChIdx=2, raise Freeze for 30 cycles while ChData[2] changes to 16'hBEEF → Hex stays "2222" and ChIdx stays 2. After Freeze falls, Hex shows "BEEF" one cycle later.
- Blanking with LEADING_ZERO_BLANK_EN: display 16'h0042 → digits 3 and 2 blank, "42" shown.
